rr_stream_mux: RTL and testbench

//   Parametrised, registered N:1 stream multiplexer with valid/ready handshakes on every port.

---
 rtl/rr_stream_mux.sv | 93 +++++++++
 tb/tb_rr_stream_mux.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: registered N:1 stream mux with round-robin or fixed select and optional packet lock
module rr_stream_mux #(
  parameter int N_CH = 4,
  parameter int WIDTH = 6,
  parameter int MODE = 0,
  parameter int LOCK = 0,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data_i,
  input  logic [N_CH-1:0]       in_valid_i,
  input  logic [N_CH-1:0]       in_last_i,
  output logic [N_CH-1:0]       in_ready_o,
  input  logic [SEL_W-1:0]      sel_i,
  output logic [WIDTH-1:0]      out_data_o,
  output logic [SEL_W-1:0]      out_ch_o,
  output logic                  out_last_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  logic [0:0] state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d, lock_ch_q, lock_ch_d, out_ch_q, out_ch_d, g, g_nxt;
  logic [WIDTH-1:0] out_data_q, out_data_d, g_data;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, load_en, gv, acc;
  logic [SEL_W:0] sum;
  // Pick the granted channel: locked owner, external select, or first requester from ptr onwards
  always_comb begin
    g = ptr_q;
    gv = 1'b0;
    sum = '0;
    if (state_q == LOCKED) begin
      g = lock_ch_q;
      gv = in_valid_i[lock_ch_q];
    end else if (MODE == 1) begin
      g = sel_i;
      gv = ({1'b0, sel_i} < (SEL_W+1)'(N_CH)) && in_valid_i[sel_i];
    end else begin
      for (int k = N_CH-1; k >= 0; k--) begin
        sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
        if (sum >= (SEL_W+1)'(N_CH)) sum = sum - (SEL_W+1)'(N_CH);
        if (in_valid_i[sum[SEL_W-1:0]]) begin
          g = sum[SEL_W-1:0];
          gv = 1'b1;
        end
      end
    end
  end
  // Route the granted channel's data towards the output register
  always_comb begin
    g_data = '0;
    for (int k = 0; k < N_CH; k++) if (g == SEL_W'(k)) g_data = in_data_i[k*WIDTH +: WIDTH];
  end
  assign load_en = !out_valid_q || out_ready_i;
  assign acc = load_en && gv && !rst;
  assign in_ready_o = acc ? {{(N_CH-1){1'b0}}, 1'b1} << g : '0;
  assign g_nxt = (g == SEL_W'(N_CH-1)) ? '0 : g + 1'b1;
  // Next-state for output register, round-robin pointer and packet lock
  always_comb begin
    out_valid_d = load_en ? acc : out_valid_q;
    out_data_d = acc ? g_data : out_data_q;
    out_ch_d = acc ? g : out_ch_q;
    out_last_d = acc ? in_last_i[g] : out_last_q;
    ptr_d = (MODE == 0 && acc && (LOCK == 0 || in_last_i[g])) ? g_nxt : ptr_q;
    state_d = (LOCK == 0) ? IDLE : !acc ? state_q : in_last_i[g] ? IDLE : LOCKED;
    lock_ch_d = (LOCK != 0 && acc && !in_last_i[g]) ? g : lock_ch_q;
  end
  // State registers; reset drops any held beat at once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q <= '0;
      out_last_q <= 1'b0;
      ptr_q <= '0;
      lock_ch_q <= '0;
      state_q <= IDLE;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
      out_last_q <= out_last_d;
      ptr_q <= ptr_d;
      lock_ch_q <= lock_ch_d;
      state_q <= state_d;
    end
  assign out_valid_o = out_valid_q;
  assign out_data_o = out_data_q;
  assign out_ch_o = out_ch_q;
  assign out_last_o = out_last_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed checks of round-robin, fixed-select and packet-lock variants
module tb_rr_stream_mux;
  localparam int N = 4;
  localparam int W = 6;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_last = '0;
  logic [S-1:0] sel = '0;
  logic out_ready = 1'b1;
  logic [N-1:0] r_rdy, f_rdy, l_rdy;
  logic [W-1:0] r_d, f_d, l_d;
  logic [S-1:0] r_ch, f_ch, l_ch;
  logic r_lst, f_lst, l_lst, r_v, f_v, l_v;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  rr_stream_mux #(.N_CH(N), .WIDTH(W), .MODE(0), .LOCK(0)) u_rr (
    .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last),
    .in_ready_o(r_rdy), .sel_i(sel), .out_data_o(r_d), .out_ch_o(r_ch), .out_last_o(r_lst),
    .out_valid_o(r_v), .out_ready_i(out_ready));
  rr_stream_mux #(.N_CH(N), .WIDTH(W), .MODE(1), .LOCK(0)) u_fx (
    .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last),
    .in_ready_o(f_rdy), .sel_i(sel), .out_data_o(f_d), .out_ch_o(f_ch), .out_last_o(f_lst),
    .out_valid_o(f_v), .out_ready_i(out_ready));
  rr_stream_mux #(.N_CH(N), .WIDTH(W), .MODE(0), .LOCK(1)) u_lk (
    .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last),
    .in_ready_o(l_rdy), .sel_i(sel), .out_data_o(l_d), .out_ch_o(l_ch), .out_last_o(l_lst),
    .out_valid_o(l_v), .out_ready_i(out_ready));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = '0;
    in_last = '0;
    sel = '0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = N*W'($urandom);
      in_valid = N'($urandom);
      in_last = N'($urandom);
      sel = S'($urandom);
      out_ready = 1'($urandom);
      tick();
      checks++; if ({r_v, r_d, r_rdy} !== '0) begin fails++; $display("FAIL reset_rr[%0d]: valid=%b data=%h ready=%b, want all 0", i, r_v, r_d, r_rdy); end
      checks++; if ({f_v, f_d, f_rdy} !== '0) begin fails++; $display("FAIL reset_fx[%0d]: valid=%b data=%h ready=%b, want all 0", i, f_v, f_d, f_rdy); end
      checks++; if ({l_v, l_d, l_rdy} !== '0) begin fails++; $display("FAIL reset_lk[%0d]: valid=%b data=%h ready=%b, want all 0", i, l_v, l_d, l_rdy); end
    end
  endtask

  task automatic test_rr_fairness;
    do_reset();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(8'h10 + i);
    in_valid = '1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (r_v !== 1'b1) begin fails++; $display("FAIL rr_valid[%0d]: got %b want 1", i, r_v); end
      checks++; if (r_ch !== S'(i % N)) begin fails++; $display("FAIL rr_ch[%0d]: got %0d want %0d", i, r_ch, i % N); end
      checks++; if (r_d !== W'(8'h10 + i % N)) begin fails++; $display("FAIL rr_data[%0d]: got %h want %h", i, r_d, 8'h10 + i % N); end
      checks++; if (r_rdy !== N'(1 << ((i + 1) % N))) begin fails++; $display("FAIL rr_ready[%0d]: got %b want %b", i, r_rdy, N'(1 << ((i + 1) % N))); end
    end
  endtask

  task automatic test_wrap;
    do_reset();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(8'h20 + i);
    in_valid = 4'b1000;
    tick();
    checks++; if (r_ch !== 2'd3 || r_d !== 6'h23) begin fails++; $display("FAIL wrap_first: ch=%0d data=%h want ch=3 data=23", r_ch, r_d); end
    in_valid = '1;
    tick();
    checks++; if (r_ch !== 2'd0 || r_d !== 6'h20) begin fails++; $display("FAIL wrap_next: ch=%0d data=%h want ch=0 data=20", r_ch, r_d); end
  endtask

  task automatic test_backpressure;
    do_reset();
    out_ready = 1'b0;
    in_valid = 4'b0001;
    in_data[0 +: W] = 6'h2A;
    tick();
    checks++; if (r_v !== 1'b1 || r_d !== 6'h2A) begin fails++; $display("FAIL bp_load: valid=%b data=%h want 1/2a", r_v, r_d); end
    in_data[0 +: W] = 6'h05;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (r_d !== 6'h2A || r_v !== 1'b1) begin fails++; $display("FAIL bp_hold[%0d]: valid=%b data=%h want 1/2a", i, r_v, r_d); end
      checks++; if (r_rdy !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, r_rdy); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (r_rdy !== 4'b0001) begin fails++; $display("FAIL bp_release_ready: got %b want 0001", r_rdy); end
    tick();
    checks++; if (r_d !== 6'h05 || r_ch !== 2'd0 || r_v !== 1'b1) begin fails++; $display("FAIL bp_next: valid=%b ch=%0d data=%h want 1/0/05", r_v, r_ch, r_d); end
    in_valid = '0;
    tick();
    checks++; if (r_v !== 1'b0) begin fails++; $display("FAIL bp_drain: valid=%b want 0", r_v); end
    in_valid = '1;
    tick();
    checks++; if (r_ch !== 2'd1) begin fails++; $display("FAIL bp_ptr_kept: ch=%0d want 1", r_ch); end
  endtask

  task automatic test_fixed;
    do_reset();
    in_data = {6'h3F, 6'h15, 6'h3F, 6'h01};
    in_valid = '1;
    sel = 2'd2;
    #1;
    checks++; if (f_rdy !== 4'b0100) begin fails++; $display("FAIL fx_ready: got %b want 0100", f_rdy); end
    tick();
    checks++; if (f_d !== 6'h15 || f_ch !== 2'd2 || f_v !== 1'b1) begin fails++; $display("FAIL fx_out: valid=%b ch=%0d data=%h want 1/2/15", f_v, f_ch, f_d); end
    sel = 2'd3;
    in_valid = 4'b0111;
    #1;
    checks++; if (f_rdy !== 4'b0000) begin fails++; $display("FAIL fx_noreq_ready: got %b want 0000", f_rdy); end
    tick();
    checks++; if (f_v !== 1'b0) begin fails++; $display("FAIL fx_noreq_valid: got %b want 0", f_v); end
    out_ready = 1'b0;
    sel = 2'd2;
    in_valid = '1;
    tick();
    checks++; if (f_ch !== 2'd2 || f_v !== 1'b1) begin fails++; $display("FAIL fx_stall_load: valid=%b ch=%0d want 1/2", f_v, f_ch); end
    sel = 2'd0;
    tick();
    checks++; if (f_ch !== 2'd2 || f_d !== 6'h15 || f_rdy !== 4'b0000) begin fails++; $display("FAIL fx_sel_stall: ch=%0d data=%h ready=%b want 2/15/0000", f_ch, f_d, f_rdy); end
    out_ready = 1'b1;
    tick();
    checks++; if (f_ch !== 2'd0 || f_d !== 6'h01) begin fails++; $display("FAIL fx_sel_apply: ch=%0d data=%h want 0/01", f_ch, f_d); end
  endtask

  task automatic test_lock;
    do_reset();
    in_data = {6'h00, 6'h00, 6'h31, 6'h01};
    in_valid = 4'b0010;
    tick();
    checks++; if (l_ch !== 2'd1 || l_d !== 6'h31 || l_lst !== 1'b0) begin fails++; $display("FAIL lk_beat1: ch=%0d data=%h last=%b want 1/31/0", l_ch, l_d, l_lst); end
    in_valid = 4'b0011;
    in_data[W +: W] = 6'h32;
    #1;
    checks++; if (l_rdy !== 4'b0010) begin fails++; $display("FAIL lk_ready: got %b want 0010", l_rdy); end
    tick();
    checks++; if (l_ch !== 2'd1 || l_d !== 6'h32) begin fails++; $display("FAIL lk_beat2: ch=%0d data=%h want 1/32", l_ch, l_d); end
    in_valid = 4'b0001;
    #1;
    checks++; if (l_rdy !== 4'b0000) begin fails++; $display("FAIL lk_gap_ready: got %b want 0000", l_rdy); end
    tick();
    checks++; if (l_v !== 1'b0) begin fails++; $display("FAIL lk_bubble: valid=%b want 0", l_v); end
    in_valid = 4'b0011;
    in_last = 4'b0010;
    in_data[W +: W] = 6'h33;
    tick();
    checks++; if (l_ch !== 2'd1 || l_d !== 6'h33 || l_lst !== 1'b1 || l_v !== 1'b1) begin fails++; $display("FAIL lk_beat3: valid=%b ch=%0d data=%h last=%b want 1/1/33/1", l_v, l_ch, l_d, l_lst); end
    in_last = '0;
    tick();
    checks++; if (l_ch !== 2'd0 || l_d !== 6'h01) begin fails++; $display("FAIL lk_release: ch=%0d data=%h want 0/01", l_ch, l_d); end
  endtask

  task automatic test_reset_mid_packet;
    do_reset();
    in_data = {6'h00, 6'h22, 6'h00, 6'h0A};
    in_valid = 4'b0100;
    out_ready = 1'b0;
    tick();
    checks++; if (l_v !== 1'b1 || l_ch !== 2'd2) begin fails++; $display("FAIL rm_setup: valid=%b ch=%0d want 1/2", l_v, l_ch); end
    #2 rst = 1'b1;
    #1;
    checks++; if (l_v !== 1'b0 || l_d !== 6'h00) begin fails++; $display("FAIL rm_async: valid=%b data=%h want 0/00", l_v, l_d); end
    #1 rst = 1'b0;
    in_valid = 4'b0101;
    out_ready = 1'b1;
    #1;
    checks++; if (l_rdy !== 4'b0001) begin fails++; $display("FAIL rm_ready: got %b want 0001", l_rdy); end
    tick();
    checks++; if (l_v !== 1'b1 || l_ch !== 2'd0 || l_d !== 6'h0A) begin fails++; $display("FAIL rm_next: valid=%b ch=%0d data=%h want 1/0/0a", l_v, l_ch, l_d); end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_wrap();
    test_backpressure();
    test_fixed();
    test_lock();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
